ysyx_040066_mem_stage: RTL

- MEM pipeline stage of the RV64 core: EX→MEM register, data-memory bus master, MEM→WB register.
- Latches the EX result, issues one aligned 64-bit load/store request per memory instruction, and stalls the pipeline until the response arrives.
- Hands WB its control fields plus the raw 64-bit read word (data_Rd), data_error and addr_lowbit; WB does the byte/half/word select and sign extension.

---
 rtl/ysyx_040066_pkg.sv | 40 ++++
 rtl/ysyx_040066_store_align.sv | 41 ++++
 rtl/ysyx_040066_mem_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_040066_pkg.sv
// Shared definitions for the MEM stage of the RV64 core.
//   XLEN            : datapath width
//   MEMOP_*         : MemOp[1:0] access-size encodings (MemOp[2]=1 means unsigned)
//   mem_state_e     : MEM-stage bus FSM states
//   load_extend()   : lane select plus sign/zero extension of a 64-bit read word
package ysyx_040066_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] MEMOP_B = 2'b00;
    localparam logic [1:0] MEMOP_H = 2'b01;
    localparam logic [1:0] MEMOP_W = 2'b10;
    localparam logic [1:0] MEMOP_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]      mem_op,
        input logic [2:0]      addr_low,
        input logic [XLEN-1:0] word
    );
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh  = word >> {addr_low, 3'b000};
        res = sh;
        case (mem_op[1:0])
            MEMOP_B: res = mem_op[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            MEMOP_H: res = mem_op[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            MEMOP_W: res = mem_op[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ysyx_040066_store_align.sv
// Store lane alignment for one 64-bit bus word (purely combinational).
//   size       : access size (MEMOP_B/H/W/D)
//   addr       : byte offset inside the aligned doubleword
//   wdata      : store source, right-aligned
//   wmask      : byte enables for the bus
//   wdata_sh   : store data shifted into its byte lanes
//   misaligned : access does not sit on its natural boundary
module ysyx_040066_store_align
    import ysyx_040066_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [2:0]      addr,
    input  logic [XLEN-1:0] wdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_sh,
    output logic            misaligned
);

    always_comb begin
        wmask      = 8'h00;
        misaligned = 1'b0;
        case (size)
            MEMOP_B: wmask = 8'h01 << addr;
            MEMOP_H: begin
                wmask      = 8'h03 << addr;
                misaligned = addr[0];
            end
            MEMOP_W: begin
                wmask      = 8'h0F << addr;
                misaligned = |addr[1:0];
            end
            default: begin
                wmask      = 8'hFF;
                misaligned = |addr;
            end
        endcase
    end

    assign wdata_sh = wdata << {addr, 3'b000};

endmodule

// File: rtl/ysyx_040066_mem_stage.sv
// MEM pipeline stage: EX->MEM register, data-memory bus master, MEM->WB register.
// One aligned 64-bit request is issued per memory instruction and the pipeline
// is stalled (block) until the response arrives or the response timer expires.
// WB receives the raw read word and does byte selection / extension itself.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ext_stall                stall request from other stages
//   *_in                     EX-stage control and data (data_in is the address)
//   req_*                    bus request channel (valid/ready handshake)
//   resp_*                   bus response channel
//   block                    global stall, also consumed by WB
//   *_out, data_Rd,
//   data_error               MEM->WB register contents
//   fwd_valid/rd/data        EX bypass of the MEM result (only with MEM_FWD_EN)
//
// Optional feature macro: MEM_FWD_EN adds the fwd_* bypass outputs.
//
// FSM states:
//   state   | meaning
//   IDLE    | no outstanding bus access; stage loads on ~block
//   REQ     | request presented, waiting for req_ready
//   WAIT    | request accepted, waiting for resp_valid or timeout
//   DONE    | access finished; behaves as IDLE until the next load edge
module ysyx_040066_mem_stage
    import ysyx_040066_pkg::*;
#(
    parameter int RESP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ext_stall,
    input  logic            valid_in,
    input  logic            wen_in,
    input  logic            MemRd_in,
    input  logic            MemWr_in,
    input  logic            done_in,
    input  logic            error_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] data_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [XLEN-1:0] nxtpc_in,
    input  logic [2:0]      MemOp_in,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_wr,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_wmask,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_rdata,
    input  logic            resp_error,
    output logic            block,
    output logic            wen_out,
    output logic            MemRd_out,
    output logic            MemWr_out,
    output logic            done_out,
    output logic            valid_out,
    output logic            error_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] nxtpc_out,
    output logic [2:0]      MemOp_out,
    output logic [2:0]      addr_lowbit_out,
    output logic [XLEN-1:0] data_Rd,
`ifdef MEM_FWD_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
`endif
    output logic            data_error
);

    localparam int            TW       = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = (RESP_TIMEOUT > 0) ? TW'(RESP_TIMEOUT - 1) : '0;

    mem_state_e state, state_nxt;

    logic            valid_q, wen_q, memrd_q, memwr_q, done_q, error_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] data_q, nxtpc_q, wdata_sh_q, rdata_q;
    logic [2:0]      memop_q;
    logic [7:0]      wmask_q;
    logic            mis_q, err_q, timeout_q;
    logic [TW-1:0]   tmo_cnt;

    logic [7:0]      wmask_in;
    logic [XLEN-1:0] wdata_sh_in;
    logic            mis_in;
    logic            mem_in, mem_go, load_en, tmo_hit;

    // Lanes are computed from the EX inputs and registered with the instruction,
    // so the request fields are stable for the whole handshake.
    ysyx_040066_store_align u_store_align (
        .size       (MemOp_in[1:0]),
        .addr       (data_in[2:0]),
        .wdata      (wdata_in),
        .wmask      (wmask_in),
        .wdata_sh   (wdata_sh_in),
        .misaligned (mis_in)
    );

    assign mem_in  = valid_in & (MemRd_in | MemWr_in);
    assign mem_go  = mem_in & ~mis_in;
    assign block   = (state == ST_REQ) | (state == ST_WAIT) | ext_stall;
    assign load_en = ~block;
    assign tmo_hit = (RESP_TIMEOUT != 0) && (tmo_cnt == '0);

    assign req_wr    = memwr_q;
    assign req_addr  = {data_q[XLEN-1:3], 3'b000};
    assign req_wdata = wdata_sh_q;
    assign req_wmask = wmask_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ext_stall does not hold REQ/WAIT: the bus access completes and parks in DONE.
    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (resp_valid || tmo_hit) state_nxt = ST_DONE;
            end
            default: begin
                if (!ext_stall) state_nxt = mem_go ? ST_REQ : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q         <= 1'b0;
            wen_q           <= 1'b0;
            memrd_q         <= 1'b0;
            memwr_q         <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            rd_q            <= '0;
            data_q          <= '0;
            nxtpc_q         <= '0;
            memop_q         <= '0;
            wmask_q         <= '0;
            wdata_sh_q      <= '0;
            mis_q           <= 1'b0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            timeout_q       <= 1'b0;
            tmo_cnt         <= '0;
            valid_out       <= 1'b0;
            wen_out         <= 1'b0;
            MemRd_out       <= 1'b0;
            MemWr_out       <= 1'b0;
            done_out        <= 1'b0;
            error_out       <= 1'b0;
            rd_out          <= '0;
            data_out        <= '0;
            nxtpc_out       <= '0;
            MemOp_out       <= '0;
            addr_lowbit_out <= '0;
            data_Rd         <= '0;
            data_error      <= 1'b0;
        end else begin
            if (load_en) begin
                // MEM -> WB takes the instruction that just finished here
                valid_out       <= valid_q;
                wen_out         <= wen_q;
                MemRd_out       <= memrd_q;
                MemWr_out       <= memwr_q;
                done_out        <= done_q;
                error_out       <= error_q;
                rd_out          <= rd_q;
                data_out        <= data_q;
                nxtpc_out       <= nxtpc_q;
                MemOp_out       <= memop_q;
                addr_lowbit_out <= data_q[2:0];
                data_Rd         <= rdata_q;
                data_error      <= valid_q & (memrd_q | memwr_q) & (err_q | mis_q | timeout_q);

                // EX -> MEM takes the next instruction; bus status starts clean
                valid_q    <= valid_in;
                wen_q      <= wen_in;
                memrd_q    <= MemRd_in;
                memwr_q    <= MemWr_in;
                done_q     <= done_in;
                error_q    <= error_in;
                rd_q       <= rd_in;
                data_q     <= data_in;
                nxtpc_q    <= nxtpc_in;
                memop_q    <= MemOp_in;
                wmask_q    <= wmask_in;
                wdata_sh_q <= wdata_sh_in;
                mis_q      <= mem_in & mis_in;
                rdata_q    <= '0;
                err_q      <= 1'b0;
                timeout_q  <= 1'b0;
            end

            if (state == ST_REQ && req_ready) tmo_cnt <= TMO_LOAD;

            if (state == ST_WAIT) begin
                if (resp_valid) begin
                    rdata_q <= resp_rdata;
                    err_q   <= resp_error;
                end else if (tmo_hit) begin
                    timeout_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt - 1'b1;
                end
            end
        end
    end

`ifdef MEM_FWD_EN
    // Loads may only be bypassed once their data is in hand.
    always_comb begin
        fwd_rd    = rd_q;
        fwd_data  = data_q;
        fwd_valid = valid_q & wen_q;
        if (memrd_q) begin
            fwd_data  = load_extend(memop_q, data_q[2:0], rdata_q);
            fwd_valid = valid_q & wen_q & (state == ST_DONE) & ~(err_q | timeout_q);
        end
    end
`endif

endmodule
